// File: rtl/program_loader.sv
// program_loader: length-prefixed byte-stream boot loader.
// Receives LEN[15:8], LEN[7:0] and LEN data bytes over a valid/ready stream,
// writes the data bytes to consecutive RAM addresses starting at BASE_ADDR,
// and holds the CPU in reset until the image has been loaded.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte; the 8-bit sum of all stream bytes, checksum included, must be zero.
module program_loader #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned CAP_W = LEN_W + 1;
    // Largest image that fits between BASE_ADDR and the top of the RAM.
    localparam logic [CAP_W-1:0] CAPACITY = CAP_W'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e              state_q,     state_d;
    logic [7:0]          len_hi_q,    len_hi_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic                in_ready_c;
    logic                xfer_c;
    logic [LEN_W-1:0]    len_full_c;
    logic                len_ovf_c;
    logic                len_zero_c;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          sum_next_c;
`endif

    // Stream handshake: ready is a pure decode of the registered state.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_LEN_HI,
            S_LEN_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK,
`endif
            S_DATA:  in_ready_c = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
    end

    assign xfer_c     = in_valid && in_ready_c;
    assign len_full_c = {len_hi_q, in_data};
    assign len_ovf_c  = {1'b0, len_full_c} > CAPACITY;
    assign len_zero_c = (len_full_c == '0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign sum_next_c = sum_q + in_data;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (xfer_c) begin
                    len_hi_d = in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d    = in_data;
`endif
                    state_d  = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (xfer_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d = sum_next_c;
`endif
                    if (len_ovf_c) begin
                        state_d = S_ERR;
                    end else if (len_zero_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        remaining_d = len_full_c;
                        addr_d      = FIRST_ADDR;
                        state_d     = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = ADDR_W'(addr_q + 1'b1);
                    remaining_d = LEN_W'(remaining_q - 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d       = sum_next_c;
`endif
                    if (remaining_q == LEN_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_c) begin
                    sum_d = sum_next_c;
                    if (sum_next_c == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`endif

            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags track the state being entered so they are registered
        // and change on the same edge as the state itself.
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
    end

    // Control state: FSM, length, counters.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running checksum over length and data bytes.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // RAM write port: one-cycle pulse per accepted data byte; reset drops any pending write.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Status outputs: CPU reset, done and error flags.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
